// File: rtl/stim_pkg.sv
// Shared types and constants for the transition stimulus sequencer:
// FSM state encoding, LFSR polynomial/seed and the Galois step function.
package stim_pkg;

    typedef enum logic [1:0] {IDLE, PRE, EVAL, DONE} state_e;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/stim_lfsr16.sv
// 16-bit Galois LFSR that advances while en is high.
// A zero seed would lock the register, so it is replaced by 16'h0001.
module stim_lfsr16
    import stim_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q, q_d, rst_val;

    assign rst_val = (seed == 16'h0000) ? 16'h0001 : seed;

    always_comb begin
        q_d = en ? lfsr_next(q_q) : q_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= rst_val;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/transition_stim_gen.sv
// Sweeps every ordered pair (i,j) of N_IN-bit vectors: i for a precharge phase, j for an
// evaluate phase, flagging the evaluate window. RAND_MASK_EN draws the mask bits from an LFSR.
module transition_stim_gen
    import stim_pkg::*;
#(
    parameter int          N_IN      = 4,
    parameter int          HOLD_CYC  = 5,
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   vec,
    output logic              phase,
    output logic              sim_start,
    output logic              sim_end,
    output logic [2*N_IN-1:0] sim_idx,
    output logic              busy,
    output logic              done
);

    localparam int PW = 2 * N_IN;

    state_e          state_q, state_d;
    logic [7:0]      hold_q, hold_d;
    logic [PW-1:0]   pair_q, pair_d, pair_inc;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            phase_q, phase_d;
    logic            sim_start_q, sim_start_d;
    logic            sim_end_q, sim_end_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            last_hold, end_next;

`ifdef RAND_MASK_EN
    logic [15:0] lfsr_q;

    stim_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy_q),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Mask bits r1,r2 come from the LFSR value present when the phase is entered.
    function automatic logic [N_IN-1:0] shape(input logic [N_IN-1:0] v);
        return {v[N_IN-1:2], lfsr_q[1:0]};
    endfunction
`else
    function automatic logic [N_IN-1:0] shape(input logic [N_IN-1:0] v);
        return v;
    endfunction
`endif

    assign pair_inc  = pair_q + PW'(1);
    assign last_hold = (hold_q == 8'(HOLD_CYC - 1));
    // sim_end is registered, so raise it one cycle ahead of the final evaluate cycle.
    assign end_next  = (HOLD_CYC >= 2) && (hold_q == 8'(HOLD_CYC - 2));

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        pair_d      = pair_q;
        vec_d       = vec_q;
        phase_d     = phase_q;
        sim_start_d = 1'b0;
        sim_end_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = PRE;
                    hold_d  = 8'd0;
                    pair_d  = '0;
                    vec_d   = shape('0);
                    phase_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            PRE: begin
                if (last_hold) begin
                    state_d     = EVAL;
                    hold_d      = 8'd0;
                    vec_d       = shape(pair_q[N_IN-1:0]);
                    phase_d     = 1'b1;
                    sim_start_d = 1'b1;
                    sim_end_d   = (HOLD_CYC == 1);
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            EVAL: begin
                if (last_hold) begin
                    hold_d = 8'd0;
                    if (&pair_q) begin
                        state_d = DONE;
                        phase_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PRE;
                        pair_d  = pair_inc;
                        vec_d   = shape(pair_inc[PW-1:N_IN]);
                        phase_d = 1'b0;
                    end
                end else begin
                    hold_d    = hold_q + 8'd1;
                    sim_end_d = end_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= 8'd0;
            pair_q      <= '0;
            vec_q       <= '0;
            phase_q     <= 1'b0;
            sim_start_q <= 1'b0;
            sim_end_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            pair_q      <= pair_d;
            vec_q       <= vec_d;
            phase_q     <= phase_d;
            sim_start_q <= sim_start_d;
            sim_end_q   <= sim_end_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign vec       = vec_q;
    assign phase     = phase_q;
    assign sim_start = sim_start_q;
    assign sim_end   = sim_end_q;
    assign sim_idx   = pair_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_transition_stim_gen.sv
// Bench for transition_stim_gen: a default instance (HOLD_CYC=5) and a HOLD_CYC=1 instance,
// both checked cycle by cycle against an arithmetic model of the sweep.
module tb_transition_stim_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [3:0] vec_a, vec_b;
    logic       phase_a, phase_b, ss_a, ss_b, se_a, se_b;
    logic [7:0] idx_a, idx_b;
    logic       busy_a, busy_b, done_a, done_b;

    int total = 0;
    int bad   = 0;

    logic [15:0] mstate = 16'hACE1;
    logic        mprev_busy = 1'b0;
    logic [1:0]  cur_mask = 2'b00;

    always #5 clk = ~clk;

    transition_stim_gen #(.N_IN(4), .HOLD_CYC(5), .LFSR_SEED(16'hACE1)) ua (
        .clk(clk), .rst_n(rst_n), .start(start_a), .vec(vec_a), .phase(phase_a),
        .sim_start(ss_a), .sim_end(se_a), .sim_idx(idx_a), .busy(busy_a), .done(done_a)
    );

    transition_stim_gen #(.N_IN(4), .HOLD_CYC(1), .LFSR_SEED(16'hACE1)) ub (
        .clk(clk), .rst_n(rst_n), .start(start_b), .vec(vec_b), .phase(phase_b),
        .sim_start(ss_b), .sim_end(se_b), .sim_idx(idx_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at sample c (c=1 is the first cycle after start is taken).
    task automatic model_chk(input string tg, input int c, input int h,
                             input logic [3:0] v, input logic ph, input logic ss,
                             input logic se, input logic [7:0] idx, input logic bz,
                             input logic dn);
        int         s, w;
        logic [7:0] s8;
        logic [3:0] ev;
        logic       exp_busy;
`ifdef RAND_MASK_EN
        logic [15:0] pre;
`endif
        exp_busy = (c <= 256 * 2 * h);
`ifdef RAND_MASK_EN
        pre = mstate;
        if (mprev_busy) mstate = lfsr_step(mstate);
        mprev_busy = exp_busy;
`endif
        if (exp_busy) begin
            s  = (c - 1) / (2 * h);
            w  = (c - 1) % (2 * h);
            s8 = 8'(s);
            ev = (w >= h) ? s8[3:0] : s8[7:4];
`ifdef RAND_MASK_EN
            if (w == 0 || w == h) cur_mask = pre[1:0];
            ev[1:0] = cur_mask;
`endif
            chk({tg, ".vec"},   32'(v),   32'(ev));
            chk({tg, ".phase"}, 32'(ph),  32'(w >= h));
            chk({tg, ".sstart"},32'(ss),  32'(w == h));
            chk({tg, ".send"},  32'(se),  32'(w == 2 * h - 1));
            chk({tg, ".idx"},   32'(idx), 32'(s8));
            chk({tg, ".busy"},  32'(bz),  32'd1);
            chk({tg, ".done"},  32'(dn),  32'd0);
        end else begin
            chk({tg, ".sstart"},32'(ss),  32'd0);
            chk({tg, ".send"},  32'(se),  32'd0);
            chk({tg, ".idx"},   32'(idx), 32'hFF);
            chk({tg, ".busy"},  32'(bz),  32'd0);
            chk({tg, ".done"},  32'(dn),  32'd1);
        end
    endtask

    task automatic chk_rst(input string tg);
        chk({tg, ".a"}, {vec_a, phase_a, ss_a, se_a, idx_a, busy_a, done_a}, 32'd0);
        chk({tg, ".b"}, {vec_b, phase_b, ss_b, se_b, idx_b, busy_b, done_b}, 32'd0);
    endtask

    task automatic go(input bit sel_b);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        mprev_busy = 1'b0;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        int nstart, nend, ncoinc;
        logic [7:0] last_idx;

        // reset, then idle
        rst_n = 1'b0;
        repeat (3) tick();
        chk_rst("reset");
        rst_n = 1'b1;
        tick();
        chk_rst("idle");

        // full sweep with a stray start at cycle 100
        go(1'b0);
        nstart = 0; nend = 0; last_idx = 8'h00;
        for (int c = 1; c <= 2565; c++) begin
            model_chk("sweep", c, 5, vec_a, phase_a, ss_a, se_a, idx_a, busy_a, done_a);
            if (ss_a) nstart++;
            if (se_a) begin nend++; last_idx = idx_a; end
            start_a = (c == 100);
            tick();
        end
        start_a = 1'b0;
        chk("t3.nstart", 32'(nstart), 32'd256);
        chk("t3.nend", 32'(nend), 32'd256);
        chk("t3.lastidx", 32'(last_idx), 32'hFF);

        // restart from DONE, async reset mid-sweep
        go(1'b0);
        for (int c = 1; c <= 1234; c++) begin
            model_chk("rerun", c, 5, vec_a, phase_a, ss_a, se_a, idx_a, busy_a, done_a);
            if (c < 1234) tick();
        end
        #2 rst_n = 1'b0;
        #1 chk_rst("t5.async");
        tick();
        chk_rst("t5.held");
        rst_n = 1'b1;
        tick();
        chk_rst("t5.release");
        mstate = 16'hACE1;
        go(1'b0);
        for (int c = 1; c <= 30; c++) begin
            model_chk("after_rst", c, 5, vec_a, phase_a, ss_a, se_a, idx_a, busy_a, done_a);
            tick();
        end

        // HOLD_CYC=1 instance
        mstate = 16'hACE1;
        go(1'b1);
        ncoinc = 0;
        for (int c = 1; c <= 516; c++) begin
            model_chk("hold1", c, 1, vec_b, phase_b, ss_b, se_b, idx_b, busy_b, done_b);
            if (ss_b && se_b) ncoinc++;
            tick();
        end
        chk("t6.coincide", 32'(ncoinc), 32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
